// File: rtl/alu_uart_pkg.sv
// Shared types and constants for the ALU result UART logger.
//   uart_state_e   : bit-level serializer states
//   HDR_BASE       : upper nibble marking a record header byte
//   FRAME_BYTES    : bytes per record (header, A, B, R, checksum)
//   frame_header() : header byte built from the op code
//   frame_checksum(): XOR of the four payload bytes
package alu_uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_BIT = 2'd1,
      DATA_BITS = 2'd2,
      STOP_BIT  = 2'd3
   } uart_state_e;

   localparam logic [7:0] HDR_BASE    = 8'hA0;
   localparam int         FRAME_BYTES = 5;
   localparam logic [2:0] LAST_BYTE   = 3'(FRAME_BYTES - 1);

   function automatic logic [7:0] frame_header(input logic [2:0] op);
      return HDR_BASE | {5'b0, op};
   endfunction

   function automatic logic [7:0] frame_checksum(input logic [7:0] hdr,
                                                 input logic [7:0] a,
                                                 input logic [7:0] b,
                                                 input logic [7:0] r);
      return hdr ^ a ^ b ^ r;
   endfunction

endpackage

// File: rtl/alu_result_uart_tx_if.sv
// Bundle between the ALU stage / host side and the UART logger.
//   start    : one-cycle strobe when the ALU op selector advances
//   op,a,b,r : ALU op code, operands and result for that step
//   tx       : UART serial line, idle high
//   busy     : frame in flight
//   done     : one-cycle pulse at end of a frame
//   drop_cnt : saturating count of strobes rejected while busy
// master = ALU/host side, slave = logger.
interface alu_result_uart_tx_if;
   logic       start;
   logic [2:0] op;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] r;
   logic       tx;
   logic       busy;
   logic       done;
   logic [7:0] drop_cnt;

   modport master (
      output start, op, a, b, r,
      input  tx, busy, done, drop_cnt
   );

   modport slave (
      input  start, op, a, b, r,
      output tx, busy, done, drop_cnt
   );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 bit serializer, LSB first, CLKS_PER_BIT clocks per bit.
//   clk, rst_n : clock, async active-low reset
//   load, data : byte to send; taken when idle or in the last cycle of a
//                stop bit, so consecutive bytes run with no idle gap
//   tx         : registered serial output, idle high
//   byte_done  : high during the final cycle of the stop bit
//
// state     | meaning
// IDLE      | line high, waiting for load
// START_BIT | line low for one bit time
// DATA_BITS | shifting data bits 0..7
// STOP_BIT  | line high for one bit time
module uart_tx_byte
   import alu_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       byte_done
);

   localparam int             TW     = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);

   uart_state_e   state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          bit_end;
   logic          take;
   logic [2:0]    bit_nxt;

   assign bit_end   = (timer_q == T_LAST);
   assign byte_done = (state_q == STOP_BIT) && bit_end;
   assign take      = load && ((state_q == IDLE) || byte_done);
   assign bit_nxt   = bit_idx_q + 3'd1;
   assign tx        = tx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
      end
   end

   // tx is computed from the next state so the pin changes on the same
   // edge as the state register.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      if (take) begin
         state_d = START_BIT;
         timer_d = '0;
         shift_d = data;
         tx_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               timer_d = '0;
               tx_d    = 1'b1;
            end
            START_BIT: begin
               if (bit_end) begin
                  state_d   = DATA_BITS;
                  timer_d   = '0;
                  bit_idx_d = 3'd0;
                  tx_d      = shift_q[0];
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            DATA_BITS: begin
               if (bit_end) begin
                  timer_d = '0;
                  if (bit_idx_q == 3'd7) begin
                     state_d = STOP_BIT;
                     tx_d    = 1'b1;
                  end else begin
                     bit_idx_d = bit_nxt;
                     tx_d      = shift_q[bit_nxt];
                  end
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            STOP_BIT: begin
               if (bit_end) begin
                  state_d = IDLE;
                  timer_d = '0;
                  tx_d    = 1'b1;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Logs each ALU step as a 5-byte UART record: header (A0|op), A, B, R,
// XOR checksum. The step is snapshotted on the accepted start strobe.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of alu_result_uart_tx_if (start/op/a/b/r in,
//                tx/busy/done/drop_cnt out)
//   CLKS_PER_BIT : clocks per UART bit, >= 2
module alu_result_uart_tx
   import alu_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_result_uart_tx_if.slave  bus
);

   logic       busy_q;
   logic       done_q;
   logic [7:0] drop_q;
   logic [2:0] byte_idx_q;
   logic [7:0] hdr_q, a_q, b_q, r_q;
   logic       accept;
   logic       byte_done;
   logic       more_bytes;
   logic       load;
   logic [7:0] load_data;
   logic [7:0] next_byte;
   logic       tx_ser;

   assign accept     = bus.start && !busy_q;
   assign more_bytes = (byte_idx_q < LAST_BYTE);
   assign load       = accept || (byte_done && more_bytes);

   // The header goes straight from the inputs on the accepting cycle; the
   // remaining bytes come from the snapshot taken on that same edge.
   always_comb begin
      next_byte = frame_checksum(hdr_q, a_q, b_q, r_q);
      case (byte_idx_q)
         3'd0:    next_byte = a_q;
         3'd1:    next_byte = b_q;
         3'd2:    next_byte = r_q;
         default: next_byte = frame_checksum(hdr_q, a_q, b_q, r_q);
      endcase
      load_data = accept ? frame_header(bus.op) : next_byte;
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .data      (load_data),
      .tx        (tx_ser),
      .byte_done (byte_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         byte_idx_q <= '0;
         hdr_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         r_q        <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            hdr_q      <= frame_header(bus.op);
            a_q        <= bus.a;
            b_q        <= bus.b;
            r_q        <= bus.r;
            byte_idx_q <= '0;
            busy_q     <= 1'b1;
         end else if (byte_done) begin
            if (more_bytes) begin
               byte_idx_q <= byte_idx_q + 3'd1;
            end else begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= '0;
      end else if (bus.start && busy_q && (drop_q != 8'hFF)) begin
         drop_q <= drop_q + 8'd1;
      end
   end

   assign bus.tx       = tx_ser;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
module tb_alu_result_uart_tx;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic s_tx   [0:409];
   logic s_busy [0:409];
   logic s_done [0:409];

   alu_result_uart_tx_if bus ();

   alu_result_uart_tx #(
      .CLKS_PER_BIT (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] r);
      bus.op = op; bus.a = a; bus.b = b; bus.r = r;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic grab(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         s_tx[i] = bus.tx; s_busy[i] = bus.busy; s_done[i] = bus.done;
         tick();
      end
   endtask

   // Recovers five bytes from 200 recorded samples starting at base;
   // bad counts framing errors and bits not exactly 4 cycles wide.
   task automatic decode(input int base, output logic [39:0] bytes, output int bad);
      logic ref_bit;
      bad = 0;
      bytes = '0;
      for (int j = 0; j < 5; j++) begin
         for (int k = 0; k < 10; k++) begin
            ref_bit = s_tx[base + (j*10 + k)*4];
            for (int c = 1; c < 4; c++)
               if (s_tx[base + (j*10 + k)*4 + c] !== ref_bit) bad++;
            if (k == 0 && ref_bit !== 1'b0) bad++;
            if (k == 9 && ref_bit !== 1'b1) bad++;
            if (k >= 1 && k <= 8) bytes[j*8 + k - 1] = ref_bit;
         end
      end
   endtask

   task automatic test_reset();
      int edges;
      bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.r = 0;
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", bus.tx); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      n_checks++; if (bus.drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop: got %h expected 00", bus.drop_cnt); end
      rst_n = 1'b1;
      edges = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0) edges++;
      end
      n_checks++; if (edges !== 0) begin n_fail++; $display("FAIL reset_idle_quiet: got %0d active cycles expected 0", edges); end
   endtask

   task automatic test_single_frame();
      logic [39:0] got;
      logic [39:0] exp;
      int bad, busy_low, done_early;
      exp = {8'h9D, 8'h0C, 8'h0F, 8'h3C, 8'hA2};
      launch(3'd2, 8'h3C, 8'h0F, 8'h0C);
      grab(0, 202);
      n_checks++; if (s_tx[0] !== 1'b0) begin n_fail++; $display("FAIL single_tx_fall: got %b expected 0", s_tx[0]); end
      busy_low = 0; done_early = 0;
      for (int i = 0; i < 200; i++) begin
         if (s_busy[i] !== 1'b1) busy_low++;
         if (s_done[i] !== 1'b0) done_early++;
      end
      n_checks++; if (busy_low !== 0) begin n_fail++; $display("FAIL single_busy_high: got %0d low cycles expected 0", busy_low); end
      n_checks++; if (done_early !== 0) begin n_fail++; $display("FAIL single_done_early: got %0d cycles expected 0", done_early); end
      n_checks++; if (s_done[200] !== 1'b1) begin n_fail++; $display("FAIL single_done_at_200: got %b expected 1", s_done[200]); end
      n_checks++; if (s_done[201] !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b expected 0", s_done[201]); end
      n_checks++; if (s_busy[200] !== 1'b0) begin n_fail++; $display("FAIL single_busy_clear: got %b expected 0", s_busy[200]); end
      decode(0, got, bad);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL single_framing: got %0d errors expected 0", bad); end
      for (int j = 0; j < 5; j++) begin
         n_checks++;
         if (got[j*8 +: 8] !== exp[j*8 +: 8]) begin
            n_fail++; $display("FAIL single_byte%0d: got %h expected %h", j, got[j*8 +: 8], exp[j*8 +: 8]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [39:0] got;
      logic [39:0] exp1;
      logic [39:0] exp2;
      int bad;
      exp1 = {8'hA4, 8'h03, 8'h02, 8'h01, 8'hA4};
      exp2 = {8'h64, 8'h40, 8'h00, 8'h81, 8'hA5};
      launch(3'd4, 8'h01, 8'h02, 8'h03);
      for (int i = 0; i < 402; i++) begin
         s_tx[i] = bus.tx; s_busy[i] = bus.busy; s_done[i] = bus.done;
         if (i == 200) begin
            bus.op = 3'd5; bus.a = 8'h81; bus.b = 8'h00; bus.r = 8'h40;
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      n_checks++; if (s_done[200] !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", s_done[200]); end
      n_checks++; if (s_tx[200] !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_cycle: got %b expected 1", s_tx[200]); end
      n_checks++; if (s_tx[201] !== 1'b0) begin n_fail++; $display("FAIL b2b_second_start: got %b expected 0", s_tx[201]); end
      n_checks++; if (s_busy[201] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %b expected 1", s_busy[201]); end
      n_checks++; if (s_done[401] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b expected 1", s_done[401]); end
      n_checks++; if (bus.drop_cnt !== 8'h00) begin n_fail++; $display("FAIL b2b_no_drop: got %h expected 00", bus.drop_cnt); end
      decode(0, got, bad);
      n_checks++; if (got !== exp1 || bad !== 0) begin n_fail++; $display("FAIL b2b_frame1: got %h err %0d expected %h err 0", got, bad, exp1); end
      decode(201, got, bad);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_frame2_framing: got %0d errors expected 0", bad); end
      for (int j = 0; j < 5; j++) begin
         n_checks++;
         if (got[j*8 +: 8] !== exp2[j*8 +: 8]) begin
            n_fail++; $display("FAIL b2b_frame2_byte%0d: got %h expected %h", j, got[j*8 +: 8], exp2[j*8 +: 8]);
         end
      end
   endtask

   task automatic test_snapshot_drop();
      logic [39:0] got;
      logic [39:0] exp;
      int bad, waited;
      exp = {8'hA1, 8'h33, 8'h22, 8'h11, 8'hA1};
      launch(3'd1, 8'h11, 8'h22, 8'h33);
      for (int i = 0; i < 202; i++) begin
         s_tx[i] = bus.tx; s_busy[i] = bus.busy; s_done[i] = bus.done;
         if (i == 10) begin
            bus.op = 3'd7; bus.a = 8'h55; bus.b = 8'h66; bus.r = 8'h77;
         end
         bus.start = (i == 20 || i == 60 || i == 100);
         tick();
      end
      bus.start = 1'b0;
      decode(0, got, bad);
      n_checks++; if (got !== exp || bad !== 0) begin n_fail++; $display("FAIL snap_frame: got %h err %0d expected %h err 0", got, bad, exp); end
      n_checks++; if (s_done[200] !== 1'b1) begin n_fail++; $display("FAIL snap_done: got %b expected 1", s_done[200]); end
      n_checks++; if (bus.drop_cnt !== 8'd3) begin n_fail++; $display("FAIL snap_drop3: got %h expected 03", bus.drop_cnt); end
      bus.start = 1'b1;
      repeat (300) tick();
      bus.start = 1'b0;
      n_checks++; if (bus.drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL drop_saturate: got %h expected ff", bus.drop_cnt); end
      waited = 0;
      while (bus.busy === 1'b1 && waited < 400) begin tick(); waited++; end
      n_checks++; if (waited >= 400) begin n_fail++; $display("FAIL drop_wait_idle: got timeout after %0d cycles expected idle", waited); end
      tick();
      n_checks++; if (bus.drop_cnt !== 8'hFF) begin n_fail++; $display("FAIL drop_no_wrap: got %h expected ff", bus.drop_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [39:0] got;
      logic [39:0] exp;
      int bad, done_seen;
      exp = {8'hA9, 8'hF0, 8'h55, 8'hAA, 8'hA6};
      launch(3'd6, 8'hAA, 8'h55, 8'hF0);
      grab(0, 90);
      // sample 90 is data bit 1 of byte 2 (0x55) -> low
      n_checks++; if (bus.tx !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset: got tx=%b busy=%b expected tx=0 busy=1", bus.tx, bus.busy); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL mid_async_tx: got %b expected 1", bus.tx); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.drop_cnt !== 8'h00) begin n_fail++; $display("FAIL mid_drop_clear: got %h expected 00", bus.drop_cnt); end
      done_seen = 0;
      repeat (3) begin tick(); if (bus.done !== 1'b0) done_seen++; end
      rst_n = 1'b1;
      repeat (5) begin tick(); if (bus.done !== 1'b0 || bus.tx !== 1'b1) done_seen++; end
      n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d bad cycles expected 0", done_seen); end
      launch(3'd6, 8'hAA, 8'h55, 8'hF0);
      grab(0, 201);
      decode(0, got, bad);
      n_checks++; if (got !== exp || bad !== 0) begin n_fail++; $display("FAIL mid_next_frame: got %h err %0d expected %h err 0", got, bad, exp); end
      n_checks++; if (s_done[200] !== 1'b1) begin n_fail++; $display("FAIL mid_next_done: got %b expected 1", s_done[200]); end
   endtask

   task automatic test_bit_timing();
      logic [39:0] got;
      logic [39:0] exp;
      logic [9:0]  bits;
      int bad;
      exp = {8'h5E, 8'hFE, 8'hFF, 8'hFF, 8'hA0};
      launch(3'd0, 8'hFF, 8'hFF, 8'hFE);
      grab(0, 201);
      for (int j = 0; j < 5; j++) begin
         bits = {1'b1, exp[j*8 +: 8], 1'b0};
         for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (s_tx[(j*10 + k)*4 + 2] !== bits[k]) begin
               n_fail++; $display("FAIL timing_byte%0d_bit%0d: got %b expected %b", j, k, s_tx[(j*10 + k)*4 + 2], bits[k]);
            end
         end
      end
      decode(0, got, bad);
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL timing_width: got %0d errors expected 0", bad); end
      n_checks++; if (s_done[200] !== 1'b1 || s_done[199] !== 1'b0) begin n_fail++; $display("FAIL timing_length: got done199=%b done200=%b expected 0/1", s_done[199], s_done[200]); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_snapshot_drop();
      test_reset_mid();
      test_bit_timing();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_result_uart_tx.md
Name: alu_result_uart_tx

Overview:
- Downstream consumer of the 8-bit auto-cycling ALU stage.
- On each op-advance strobe, snapshots the operation code, both operands and the ALU result.
- Transmits them on a single UART pin as a 5-byte framed record (header, A, B, R, checksum), 8N1, LSB first.
- Lets a host log every ALU step without using extra pins.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200, truncated); legal range >= 2.
- FRAME_BYTES, 5, bytes per record; fixed, not to be overridden.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle strobe, asserted when the ALU op selector advances
- op  in  3  ALU operation code (0..5 normal; 6..7 passed through unchanged)
- a  in  8  operand A
- b  in  8  operand B
- r  in  8  ALU result
- tx  out  1  UART serial line, idle high
- busy  out  1  high while a frame is in flight
- done  out  1  one-cycle pulse when a frame completes
- drop_cnt  out  8  saturating count of strobes rejected while busy

Behaviour:
- Reset (async, rst_n low):
  - tx=1, busy=0, done=0, drop_cnt=0, state=IDLE.
  - Any frame in progress is abandoned immediately; tx returns high asynchronously.
- Accept rule:
  - start is accepted only when state==IDLE.
  - On accept, the cycle's op/a/b/r are latched into a 4-byte snapshot; later input changes do not affect the frame.
- Frame bytes, in order:
  - byte0 = 8'hA0 | {5'b0,op}
  - byte1 = a
  - byte2 = b
  - byte3 = r
  - byte4 = byte0^byte1^byte2^byte3
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. Consecutive bytes are back-to-back with no idle gap.
- Latency: tx falls to 0 and busy rises on the first clk edge after the accepting edge, i.e. both are registered outputs.
- Frame length: 5*10*CLKS_PER_BIT cycles from tx falling to the end of the last stop bit.
- FSM states:
  - IDLE: tx=1. On start, go to START_BIT, byte_idx=0.
  - START_BIT: tx=0 for CLKS_PER_BIT cycles, then go to DATA_BITS, bit_idx=0.
  - DATA_BITS: tx=shift[bit_idx]. After each CLKS_PER_BIT cycles, increment bit_idx; after bit 7, go to STOP_BIT.
  - STOP_BIT: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<4, increment byte_idx and go to START_BIT; else go to IDLE.
- Completion:
  - On the transition STOP_BIT(byte 4) -> IDLE: done<=1 for exactly one cycle, busy<=0 on the same edge.
  - A start in that done cycle is accepted, so back-to-back frames are separated by exactly one idle-high cycle.
- Drops:
  - start while state!=IDLE: strobe ignored, snapshot unchanged, drop_cnt increments.
  - drop_cnt saturates at 8'hFF and never wraps.
  - Only reset clears drop_cnt.
- Counter widths:
  - Bit-timer width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and reloads.
  - bit_idx is 3 bits; byte_idx is 3 bits.
- start held high for several cycles: the first cycle is accepted; each following high cycle while busy is counted as a drop.

Decomposition:
- Package alu_uart_pkg holds:
  - state enum {IDLE, START_BIT, DATA_BITS, STOP_BIT}
  - HDR_BASE=8'hA0
  - FRAME_BYTES=5
  - function frame_checksum(hdr,a,b,r)
- One sub-module: uart_tx_byte.
  - Bit-level serializer with inputs load/data[7:0] and outputs tx/byte_done, parameterised by CLKS_PER_BIT.
  - The top holds the snapshot, byte sequencing, done/busy and drop_cnt logic.

Test Plan (bench uses CLKS_PER_BIT=4):
- Reset idle: hold rst_n low, release -> tx=1, busy=0, drop_cnt=0; no tx edge for 100 cycles.
- Single frame: start with op=2, a=8'h3C, b=8'h0F, r=8'h0C -> decoded bytes A2,3C,0F,0C,9D.
  - tx falls 1 cycle after the start edge; done pulses exactly 200 cycles later.
  - busy is high throughout.
- Snapshot hold and drop:
  - Change a/b/r mid-frame and pulse start 3 times -> frame bytes unchanged, drop_cnt=3.
  - Force 300 busy-time strobes -> drop_cnt=8'hFF.
- Back-to-back: pulse start in the done cycle with op=5, a=8'h81, r=8'h40, b=8'h00 -> second frame A5,81,00,40,64 after exactly one idle-high cycle.
- Reset mid-frame: assert rst_n during byte 2 data bits -> tx=1 asynchronously, busy=0, no done pulse; next start yields a complete correct frame.
- Bit timing: sample tx at bit centres for op=0, a=8'hFF, b=8'hFF, r=8'hFE -> bytes A0,FF,FF,FE,5E; every bit width is exactly 4 cycles.
